// File: rtl/p_box_inv_pipe_pkg.sv
// Shared DES permutation tables and helpers. Bit 1 is the MSB (DES numbering).
package p_box_inv_pipe_pkg;

    localparam int unsigned DES_W = 32;

    // Words are declared [1:32] so table entries index bits directly.
    typedef logic [1:DES_W] des_word_t;

    // Forward round permutation P: out[j] = in[P_FWD[j]].
    localparam int P_FWD [1:DES_W] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Inverse of P: out[j] = in[P_INV[j]], so P_INV[P_FWD[j]] == j.
    localparam int P_INV [1:DES_W] = '{
         9, 17, 23, 31, 13, 28,  2, 18,
        24, 16, 30,  6, 26, 20, 10,  1,
         8, 14, 25,  3,  4, 29, 11, 19,
        32, 12, 22,  7,  5, 27, 15, 21
    };

    // Skid FSM encoding.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    function automatic des_word_t p_fwd(input des_word_t d);
        des_word_t r;
        for (int j = 1; j <= DES_W; j++) begin
            r[j] = d[P_FWD[j]];
        end
        return r;
    endfunction

    function automatic des_word_t p_inv(input des_word_t d);
        des_word_t r;
        for (int j = 1; j <= DES_W; j++) begin
            r[j] = d[P_INV[j]];
        end
        return r;
    endfunction

endpackage

// File: rtl/p_box_inv_32_32.sv
// Purely combinational inverse of the DES round permutation P.
module p_box_inv_32_32
    import p_box_inv_pipe_pkg::*;
(
    input  logic [1:32] data_i,
    output logic [1:32] data_o
);

    // Pure bit routing through the inverse table.
    always_comb begin
        data_o = p_inv(data_i);
    end

endmodule

// File: rtl/p_box_inv_pipe.sv
// Registered P / inverse-P stage with a 2-entry skid buffer on a valid/ready stream.
// Words are permuted before storage, so both registers hold output-ready data.
module p_box_inv_pipe
    import p_box_inv_pipe_pkg::*;
#(
    parameter int          DIR   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_box_inv_pipe_flush_i,
    input  logic             p_box_inv_pipe_valid_i,
    output logic             p_box_inv_pipe_ready_o,
    input  logic [1:32]      p_box_inv_pipe_data_i,
    output logic             p_box_inv_pipe_valid_o,
    input  logic             p_box_inv_pipe_ready_i,
    output logic [1:32]      p_box_inv_pipe_data_o,
    output logic [CNT_W-1:0] p_box_inv_pipe_count_o
);

    logic [1:0]       state_q, state_d;
    logic [1:32]      main_q, main_d;
    logic [1:32]      skid_q, skid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:32]      perm_w;
    logic             accept;
    logic             xfer;

    if (DIR != 0) begin : g_inv
        p_box_inv_32_32 u_inv (
            .data_i (p_box_inv_pipe_data_i),
            .data_o (perm_w)
        );
    end else begin : g_fwd
        assign perm_w = p_fwd(p_box_inv_pipe_data_i);
    end

    // Outputs decode registered state only; ready never sees ready_i/valid_i.
    assign p_box_inv_pipe_ready_o = (state_q != ST_TWO);
    assign p_box_inv_pipe_valid_o = (state_q != ST_EMPTY);
    assign p_box_inv_pipe_data_o  = main_q;
    assign p_box_inv_pipe_count_o = count_q;

    assign accept = p_box_inv_pipe_valid_i & p_box_inv_pipe_ready_o;
    assign xfer   = p_box_inv_pipe_valid_o & p_box_inv_pipe_ready_i;

    // Next-state for the skid FSM, storage and delivered-word counter.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q;

        // A transfer counts even when a flush discards the storage update.
        if (xfer) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (p_box_inv_pipe_flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = perm_w;
                    end
                end
                ST_ONE: begin
                    if (accept && xfer) begin
                        main_d = perm_w;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_d  = perm_w;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // ready_o is low here, so only a drain can happen.
                    if (xfer) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and data registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_p_box_inv_pipe.sv
// Directed bench for p_box_inv_pipe: reset, single bits, backpressure, flush,
// mid-stream reset, forward/inverse round trip and counter wrap.
module tb_p_box_inv_pipe;

    logic clk;
    logic rst;

    int total;
    int bad;

    // Main DIR=1 instance.
    logic        m_flush, m_valid_i, m_ready_o, m_valid_o, m_ready_i;
    logic [31:0] m_data_i, m_data_o;
    logic [15:0] m_count;

    // Round trip: forward instance feeding inverse instance.
    logic        rt_valid_i, f_ready_o, f_valid_o, i_ready_o, i_valid_o, rt_ready, zero;
    logic [31:0] rt_data_i, f_data_o, i_data_o;
    logic [15:0] f_count, i_count;

    // Wrap instance, CNT_W=4.
    logic        w_valid_i, w_ready_o, w_valid_o, w_ready_i;
    logic [31:0] w_data_i, w_data_o;
    logic [3:0]  w_count;

    // Golden combinational inverse.
    logic [31:0] model_in, model_out;

    logic [31:0] rt_words [1000];

    p_box_inv_pipe #(.DIR(1), .CNT_W(16)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .p_box_inv_pipe_flush_i (m_flush),
        .p_box_inv_pipe_valid_i (m_valid_i),
        .p_box_inv_pipe_ready_o (m_ready_o),
        .p_box_inv_pipe_data_i  (m_data_i),
        .p_box_inv_pipe_valid_o (m_valid_o),
        .p_box_inv_pipe_ready_i (m_ready_i),
        .p_box_inv_pipe_data_o  (m_data_o),
        .p_box_inv_pipe_count_o (m_count)
    );

    p_box_inv_pipe #(.DIR(0), .CNT_W(16)) u_fwd (
        .clk                    (clk),
        .rst                    (rst),
        .p_box_inv_pipe_flush_i (zero),
        .p_box_inv_pipe_valid_i (rt_valid_i),
        .p_box_inv_pipe_ready_o (f_ready_o),
        .p_box_inv_pipe_data_i  (rt_data_i),
        .p_box_inv_pipe_valid_o (f_valid_o),
        .p_box_inv_pipe_ready_i (i_ready_o),
        .p_box_inv_pipe_data_o  (f_data_o),
        .p_box_inv_pipe_count_o (f_count)
    );

    p_box_inv_pipe #(.DIR(1), .CNT_W(16)) u_inv (
        .clk                    (clk),
        .rst                    (rst),
        .p_box_inv_pipe_flush_i (zero),
        .p_box_inv_pipe_valid_i (f_valid_o),
        .p_box_inv_pipe_ready_o (i_ready_o),
        .p_box_inv_pipe_data_i  (f_data_o),
        .p_box_inv_pipe_valid_o (i_valid_o),
        .p_box_inv_pipe_ready_i (rt_ready),
        .p_box_inv_pipe_data_o  (i_data_o),
        .p_box_inv_pipe_count_o (i_count)
    );

    p_box_inv_pipe #(.DIR(1), .CNT_W(4)) u_wrap (
        .clk                    (clk),
        .rst                    (rst),
        .p_box_inv_pipe_flush_i (zero),
        .p_box_inv_pipe_valid_i (w_valid_i),
        .p_box_inv_pipe_ready_o (w_ready_o),
        .p_box_inv_pipe_data_i  (w_data_i),
        .p_box_inv_pipe_valid_o (w_valid_o),
        .p_box_inv_pipe_ready_i (w_ready_i),
        .p_box_inv_pipe_data_o  (w_data_o),
        .p_box_inv_pipe_count_o (w_count)
    );

    p_box_inv_32_32 u_model (
        .data_i (model_in),
        .data_o (model_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        zero = 1'b0;
        m_flush = 1'b0; m_valid_i = 1'b0; m_ready_i = 1'b1; m_data_i = '0;
        rt_valid_i = 1'b0; rt_data_i = '0; rt_ready = 1'b1;
        w_valid_i = 1'b0; w_data_i = '0; w_ready_i = 1'b1;
        model_in = '0;

        #1;
        check("rst_valid", {31'd0, m_valid_o}, 32'd0);
        check("rst_data",  m_data_o, 32'h0);
        check("rst_count", {16'd0, m_count}, 32'd0);
        check("rst_ready", {31'd0, m_ready_o}, 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // Single bits and a third directed vector at full rate.
        m_valid_i = 1'b1; m_data_i = 32'h8000_0000;
        tick();
        check("bit1_valid", {31'd0, m_valid_o}, 32'd1);
        check("bit1_data",  m_data_o, 32'h0001_0000);
        m_data_i = 32'h0000_0001;
        tick();
        check("bit32_data", m_data_o, 32'h0000_0080);
        m_data_i = 32'h4000_0000;
        tick();
        check("bit2_data", m_data_o, 32'h0200_0000);
        m_valid_i = 1'b0;
        tick();
        check("drain_valid", {31'd0, m_valid_o}, 32'd0);
        check("count3", {16'd0, m_count}, 32'd3);

        // One arbitrary word against the combinational model.
        m_valid_i = 1'b1; m_data_i = 32'hDEAD_BEEF; model_in = 32'hDEAD_BEEF;
        tick();
        check("model_data", m_data_o, model_out);
        m_valid_i = 1'b0;
        tick();
        check("count4", {16'd0, m_count}, 32'd4);

        // Backpressure: three offered, two accepted.
        m_ready_i = 1'b0;
        m_valid_i = 1'b1; m_data_i = 32'h8000_0000;
        tick();
        check("bp_ready_one", {31'd0, m_ready_o}, 32'd1);
        m_data_i = 32'h0000_0001;
        tick();
        check("bp_ready_two", {31'd0, m_ready_o}, 32'd0);
        m_data_i = 32'h4000_0000;
        tick();
        check("bp_hold_ready", {31'd0, m_ready_o}, 32'd0);
        check("bp_hold_data", m_data_o, 32'h0001_0000);
        m_valid_i = 1'b0; m_ready_i = 1'b1;
        tick();
        check("bp_second_data", m_data_o, 32'h0000_0080);
        check("bp_second_valid", {31'd0, m_valid_o}, 32'd1);
        check("bp_ready_back", {31'd0, m_ready_o}, 32'd1);
        tick();
        check("bp_empty", {31'd0, m_valid_o}, 32'd0);
        check("bp_count", {16'd0, m_count}, 32'd6);

        // Flush in TWO with an offered word.
        m_ready_i = 1'b0;
        m_valid_i = 1'b1; m_data_i = 32'h1234_5678;
        tick();
        m_data_i = 32'h9ABC_DEF0;
        tick();
        check("fl_pre_ready", {31'd0, m_ready_o}, 32'd0);
        m_flush = 1'b1; m_data_i = 32'h0F0F_0F0F;
        tick();
        check("fl_valid", {31'd0, m_valid_o}, 32'd0);
        check("fl_ready", {31'd0, m_ready_o}, 32'd1);
        check("fl_count", {16'd0, m_count}, 32'd6);
        m_flush = 1'b0; m_valid_i = 1'b0; m_ready_i = 1'b1;
        tick();
        check("fl_gone1", {31'd0, m_valid_o}, 32'd0);
        tick();
        check("fl_gone2", {31'd0, m_valid_o}, 32'd0);
        check("fl_count2", {16'd0, m_count}, 32'd6);

        // Asynchronous reset while a word is held.
        m_ready_i = 1'b0; m_valid_i = 1'b1; m_data_i = 32'h8000_0000;
        tick();
        check("mr_pre_valid", {31'd0, m_valid_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("mr_valid", {31'd0, m_valid_o}, 32'd0);
        check("mr_data",  m_data_o, 32'h0);
        check("mr_count", {16'd0, m_count}, 32'd0);
        check("mr_ready", {31'd0, m_ready_o}, 32'd1);
        #2;
        rst = 1'b0;
        m_valid_i = 1'b0; m_ready_i = 1'b1;
        tick();
        check("mr_post_valid", {31'd0, m_valid_o}, 32'd0);

        // Round trip at full rate: word k appears after edge k+2.
        for (int k = 0; k < 1000; k++) rt_words[k] = $urandom;
        for (int k = 1; k <= 1001; k++) begin
            if (k - 1 < 1000) begin
                rt_valid_i = 1'b1;
                rt_data_i  = rt_words[k-1];
            end else begin
                rt_valid_i = 1'b0;
            end
            tick();
            if (k >= 2) begin
                check("rt_valid", {31'd0, i_valid_o}, 32'd1);
                check("rt_data", i_data_o, rt_words[k-2]);
            end
        end
        tick();
        check("rt_fwd_count", {16'd0, f_count}, 32'd1000);
        check("rt_inv_count", {16'd0, i_count}, 32'd1000);
        check("rt_empty", {31'd0, i_valid_o}, 32'd0);

        // 17 deliveries on a 4-bit counter.
        w_valid_i = 1'b1;
        for (int k = 0; k < 17; k++) begin
            w_data_i = k;
            tick();
        end
        w_valid_i = 1'b0;
        tick();
        check("wrap_count", {28'd0, w_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
